// File: rtl/jk_clk_step_gen_if.sv
// rtl/jk_clk_step_gen_if.sv - button/switch inputs and clock/JK outputs of the step generator
interface jk_clk_step_gen_if;
    logic       BTN_STEP;
    logic       BTN_MODE;
    logic [1:0] SW_J;
    logic [1:0] SW_K;
    logic       CLK_OUT;
    logic       MODE;
    logic [1:0] J_OUT;
    logic [1:0] K_OUT;
    logic [7:0] EDGE_CNT;

    modport master (
        output BTN_STEP, BTN_MODE, SW_J, SW_K,
        input  CLK_OUT, MODE, J_OUT, K_OUT, EDGE_CNT
    );

    modport slave (
        input  BTN_STEP, BTN_MODE, SW_J, SW_K,
        output CLK_OUT, MODE, J_OUT, K_OUT, EDGE_CNT
    );
endinterface

// File: rtl/jk_clk_step_gen.sv
// rtl/jk_clk_step_gen.sv - debounced step/run clock generator with J/K capture and edge counter
module jk_clk_step_gen #(
    parameter int DEB_CYCLES = 50000,
    parameter int PULSE_LEN  = 4,
    parameter int HALF       = 25000000
) (
    input  logic              CLK,
    input  logic              CLR,
    jk_clk_step_gen_if.slave  io
);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (PULSE_LEN > HALF) ? PULSE_LEN : HALF;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {STEP_IDLE, STEP_HI, RUN_LO, RUN_HI} state_t;

    // raw bit order: {step, mode, J[1:0], K[1:0]}
    logic [5:0] raw;
    logic [5:0] s1_q, s2_q;
    assign raw = {io.BTN_STEP, io.BTN_MODE, io.SW_J, io.SW_K};

    logic [1:0]         btn_s;
    logic [1:0]         deb_q, deb_d, deb_prev_q;
    logic [1:0][DW-1:0] dcnt_q, dcnt_d;
    logic               step_req, mode_req;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_q, pend_d;
    logic          clk_out_q, clk_out_d;
    logic          mode_q, mode_d;
    logic [1:0]    j_q, j_d, k_q, k_d;
    logic [7:0]    edge_cnt_q, edge_cnt_d;

    assign btn_s = s2_q[5:4];

    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int b = 0; b < 2; b++) begin
            if (btn_s[b] != deb_q[b]) begin
                if (dcnt_q[b] == DW'(DEB_CYCLES - 1)) begin
                    deb_d[b] = btn_s[b];
                end else begin
                    dcnt_d[b] = dcnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign step_req = deb_q[1] & ~deb_prev_q[1];
    assign mode_req = deb_q[0] & ~deb_prev_q[0];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        pend_d  = pend_q;
        case (state_q)
            STEP_IDLE: begin
                timer_d = '0;
                if (mode_req) begin
                    state_d = RUN_LO;
                end else if (step_req) begin
                    state_d = STEP_HI;
                end
            end
            STEP_HI: begin
                if (mode_req) pend_d = 1'b1;
                if (timer_q == TW'(PULSE_LEN - 1)) begin
                    timer_d = '0;
                    pend_d  = 1'b0;
                    state_d = (pend_q | mode_req) ? RUN_LO : STEP_IDLE;
                end
            end
            RUN_LO: begin
                if (mode_req) begin
                    state_d = STEP_IDLE;
                    timer_d = '0;
                    pend_d  = 1'b0;
                end else if (timer_q == TW'(HALF - 1)) begin
                    state_d = RUN_HI;
                    timer_d = '0;
                end
            end
            RUN_HI: begin
                // a mode exit lets the high phase finish so no short pulse is emitted
                if (mode_req) pend_d = 1'b1;
                if (timer_q == TW'(HALF - 1)) begin
                    timer_d = '0;
                    pend_d  = 1'b0;
                    state_d = (pend_q | mode_req) ? STEP_IDLE : RUN_LO;
                end
            end
            default: begin
                state_d = STEP_IDLE;
                timer_d = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        clk_out_d  = (state_d == STEP_HI) || (state_d == RUN_HI);
        mode_d     = (state_d == RUN_LO) || (state_d == RUN_HI);
        j_d        = j_q;
        k_d        = k_q;
        edge_cnt_d = edge_cnt_q;
        if (!clk_out_q && clk_out_d) begin
            j_d = s2_q[3:2];
            k_d = s2_q[1:0];
        end
        if (clk_out_q && !clk_out_d) begin
            edge_cnt_d = edge_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            dcnt_q     <= '0;
            state_q    <= STEP_IDLE;
            timer_q    <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            mode_q     <= 1'b0;
            j_q        <= '0;
            k_q        <= '0;
            edge_cnt_q <= '0;
        end else begin
            s1_q       <= raw;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            dcnt_q     <= dcnt_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            mode_q     <= mode_d;
            j_q        <= j_d;
            k_q        <= k_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign io.CLK_OUT  = clk_out_q;
    assign io.MODE     = mode_q;
    assign io.J_OUT    = j_q;
    assign io.K_OUT    = k_q;
    assign io.EDGE_CNT = edge_cnt_q;
endmodule

// File: tb/tb_jk_clk_step_gen.sv
// tb/tb_jk_clk_step_gen.sv - scoreboard bench for jk_clk_step_gen
module tb_jk_clk_step_gen;
    logic CLK = 1'b0;
    logic CLR;
    always #5 CLK = ~CLK;

    jk_clk_step_gen_if io ();

    jk_clk_step_gen #(.DEB_CYCLES(4), .PULSE_LEN(3), .HALF(5)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .io  (io)
    );

    typedef struct {
        int       len;
        int       cnt;
        logic [1:0] j;
        logic [1:0] k;
        logic     mode;
        int       period;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   skip_fall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int len, input int cnt, input logic [1:0] j,
                        input logic [1:0] k, input logic mode, input int period);
        exp_t e;
        e.len = len; e.cnt = cnt; e.j = j; e.k = k; e.mode = mode; e.period = period;
        q.push_back(e);
    endtask

    // Monitor: every CLK_OUT fall is a DUT output event checked against the queue
    initial begin
        logic prev;
        int   hi;
        int   since;
        exp_t e;
        prev = 1'b0; hi = 0; since = 0;
        forever begin
            @(negedge CLK);
            since++;
            if (io.CLK_OUT === 1'b1) hi++;
            if (prev === 1'b1 && io.CLK_OUT === 1'b0) begin
                if (!skip_fall) begin
                    if (q.size() == 0) begin
                        chk("unexpected_fall", 32'(io.EDGE_CNT), 32'hffff_ffff);
                    end else begin
                        e = q.pop_front();
                        chk("hi_len",   32'(hi),          32'(e.len));
                        chk("edge_cnt", 32'(io.EDGE_CNT), 32'(e.cnt));
                        chk("j_out",    32'(io.J_OUT),    32'(e.j));
                        chk("k_out",    32'(io.K_OUT),    32'(e.k));
                        chk("mode",     32'(io.MODE),     32'(e.mode));
                        if (e.period != 0) chk("period", 32'(since), 32'(e.period));
                    end
                end
                hi = 0;
                since = 0;
            end
            prev = io.CLK_OUT;
        end
    end

    task automatic press(input bit is_mode, input int hold);
        if (is_mode) io.BTN_MODE = 1'b1; else io.BTN_STEP = 1'b1;
        repeat (hold) @(negedge CLK);
        io.BTN_MODE = 1'b0;
        io.BTN_STEP = 1'b0;
        repeat (hold) @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_cnt(input int target, input int budget);
        int n;
        n = 0;
        while (io.EDGE_CNT != 8'(target) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_edge_cnt", 32'(io.EDGE_CNT), 32'(target));
    endtask

    task automatic wait_high(input int budget);
        int n;
        n = 0;
        while (io.CLK_OUT !== 1'b1 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("wait_clk_high", 32'(io.CLK_OUT), 32'd1);
    endtask

    initial begin
        CLR = 1'b1;
        io.BTN_STEP = 1'b0; io.BTN_MODE = 1'b0; io.SW_J = 2'b00; io.SW_K = 2'b00;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            io.BTN_STEP = 1'($urandom); io.BTN_MODE = 1'($urandom);
            io.SW_J = 2'($urandom); io.SW_K = 2'($urandom);
        end
        @(negedge CLK);
        chk("rst_clk_out",  32'(io.CLK_OUT),  32'd0);
        chk("rst_mode",     32'(io.MODE),     32'd0);
        chk("rst_j",        32'(io.J_OUT),    32'd0);
        chk("rst_k",        32'(io.K_OUT),    32'd0);
        chk("rst_edge_cnt", 32'(io.EDGE_CNT), 32'd0);
        CLR = 1'b0;
        io.BTN_STEP = 1'b0; io.BTN_MODE = 1'b0; io.SW_J = 2'b00; io.SW_K = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("idle_clk_out", 32'(io.CLK_OUT), 32'd0);
        end

        // Bounce rejection, then a clean press
        for (int i = 0; i < 10; i++) begin
            io.BTN_STEP = ~io.BTN_STEP;
            repeat (2) @(negedge CLK);
        end
        io.BTN_STEP = 1'b0;
        repeat (10) @(negedge CLK);
        chk("bounce_edge_cnt", 32'(io.EDGE_CNT), 32'd0);
        push(3, 1, 2'b00, 2'b00, 1'b0, 0);
        press(1'b0, 10);
        chk("after_press_cnt", 32'(io.EDGE_CNT), 32'd1);

        // J/K capture held through the falling edge
        io.SW_J = 2'b01; io.SW_K = 2'b11;
        repeat (5) @(negedge CLK);
        push(3, 2, 2'b01, 2'b11, 1'b0, 0);
        io.BTN_STEP = 1'b1;
        wait_high(30);
        io.SW_J = 2'b10; io.SW_K = 2'b00;
        repeat (8) @(negedge CLK);
        io.BTN_STEP = 1'b0;
        repeat (12) @(negedge CLK);
        push(3, 3, 2'b10, 2'b00, 1'b0, 0);
        press(1'b0, 10);

        // Run mode: 30 periods, step ignored, exit during high phase
        do_reset();
        io.SW_J = 2'b11; io.SW_K = 2'b01;
        for (int i = 0; i < 34; i++) push(5, i + 1, 2'b11, 2'b01, 1'b1, (i == 0) ? 0 : 10);
        push(5, 35, 2'b11, 2'b01, 1'b0, 10);
        press(1'b1, 10);
        chk("run_mode", 32'(io.MODE), 32'd1);
        wait_cnt(30, 400);
        press(1'b0, 10);
        wait_cnt(34, 100);
        io.BTN_MODE = 1'b1;
        repeat (10) @(negedge CLK);
        io.BTN_MODE = 1'b0;
        repeat (30) @(negedge CLK);
        chk("exit_mode", 32'(io.MODE), 32'd0);
        chk("exit_cnt",  32'(io.EDGE_CNT), 32'd35);

        // 256 pulses wrap the counter, then one more
        do_reset();
        io.SW_J = 2'b10; io.SW_K = 2'b11;
        repeat (4) @(negedge CLK);
        for (int i = 0; i < 257; i++) begin
            push(3, (i + 1) % 256, 2'b10, 2'b11, 1'b0, 0);
            press(1'b0, 10);
        end
        chk("wrap_cnt", 32'(io.EDGE_CNT), 32'd1);

        // Reset during a step pulse: the drop is not counted
        skip_fall = 1'b1;
        io.BTN_STEP = 1'b1;
        wait_high(30);
        CLR = 1'b1;
        io.BTN_STEP = 1'b0;
        @(negedge CLK);
        chk("midrst_clk_out",  32'(io.CLK_OUT),  32'd0);
        chk("midrst_edge_cnt", 32'(io.EDGE_CNT), 32'd0);
        chk("midrst_j",        32'(io.J_OUT),    32'd0);
        CLR = 1'b0;
        repeat (20) @(negedge CLK);
        skip_fall = 1'b0;
        repeat (10) @(negedge CLK);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_clk_step_gen.md
# jk_clk_step_gen

Upstream clock and stimulus generator for the lab-board dual JK flip-flop chip model. It debounces two push buttons and produces a clean clock on `CLK_OUT`: one pulse per button press in step mode, or a divided free-running square wave in run mode. It registers the J/K switch settings so that they stay stable across every active falling edge, and it counts the falling edges it delivers. `CLK_OUT`, `J_OUT` and `K_OUT` drive the flip-flop chip's clock and J/K pins directly.

## Interface
- `DEB_CYCLES`, default 50000: consecutive synchronised cycles a button must differ from its debounced value before the debounced value changes (≥2).
- `PULSE_LEN`, default 4: `CLK_OUT` high-time in step mode, in cycles (≥1).
- `HALF`, default 25000000: `CLK_OUT` high-time and low-time in run mode, in cycles (≥1).
- `CLK`  in  1  system clock; all logic is on the rising edge.
- `CLR`  in  1  reset, synchronous, active-high.
- `BTN_STEP`  in  1  raw step button, active-high, asynchronous.
- `BTN_MODE`  in  1  raw mode button, active-high, asynchronous.
- `SW_J`  in  2  raw J switches, bit n drives flip-flop n.
- `SW_K`  in  2  raw K switches.
- `CLK_OUT`  out  1  generated clock; the falling edge is the active edge downstream.
- `MODE`  out  1  0 = step mode, 1 = run mode.
- `J_OUT`  out  2  registered J values.
- `K_OUT`  out  2  registered K values.
- `EDGE_CNT`  out  8  number of `CLK_OUT` 1→0 transitions.

## Operation
- **Input synchronisers.** All raw inputs pass through a 2-flop synchroniser.
- **Debouncers (one per button).**
  - A counter increments while the synchronised input differs from the debounced value.
  - The counter clears whenever the two are equal.
  - When the count reaches `DEB_CYCLES`, the debounced value takes the synchronised value and the counter clears.
  - A rising edge of a debounced button is a one-cycle request (`step_req` or `mode_req`).
- **State machine states:** `STEP_IDLE`, `STEP_HI`, `RUN_LO`, `RUN_HI`. `CLK_OUT` is 1 only in the `_HI` states. `MODE` is 1 only in the `RUN_` states. A phase timer counts cycles spent in the current `_HI` or `RUN_` phase.
- **`STEP_IDLE`:**
  - `mode_req` → `RUN_LO`, timer cleared.
  - Otherwise `step_req` → `STEP_HI`.
  - If both requests arrive in the same cycle, mode wins and the step request is dropped.
- **`STEP_HI`:**
  - After `PULSE_LEN` cycles → `STEP_IDLE`.
  - `step_req` in this state is ignored; requests are not queued.
  - `mode_req` sets a pending flag. At the end of the pulse the machine goes to `RUN_LO` instead of `STEP_IDLE`.
- **`RUN_LO`:**
  - After `HALF` cycles → `RUN_HI`.
  - `mode_req` → `STEP_IDLE` on the next cycle; `CLK_OUT` stays 0.
- **`RUN_HI`:**
  - After `HALF` cycles → `RUN_LO`.
  - `mode_req` sets the pending flag. At the end of the phase the machine goes to `STEP_IDLE`.
- **Requests in run mode.** `step_req` is ignored in `RUN_LO` and `RUN_HI`.
- **J/K capture.** On every cycle in which `CLK_OUT` goes 0→1, `J_OUT`/`K_OUT` load the synchronised switch values. They are held until the next rising edge, so they are stable through each falling edge.
- **Edge counter.** `EDGE_CNT` increments on each cycle in which `CLK_OUT` goes 1→0, and wraps from 255 to 0.

## Timing
- **Reset** (`CLR` = 1 at a rising edge):
  - On the next edge, `CLK_OUT`, `MODE`, `J_OUT`, `K_OUT` and `EDGE_CNT` are all 0.
  - State becomes `STEP_IDLE`; the debounced values, counters, timer and pending flag are cleared.
  - `CLR` has priority over all other inputs.
- **Reset mid-pulse.** `CLK_OUT` drops to 0, and `EDGE_CNT` reads 0; the drop is not counted.
- **Synchroniser latency:** 2 cycles.
- **Debounce latency.** The debounced value changes on the `DEB_CYCLES`-th consecutive differing cycle.
- **Step latency.** `CLK_OUT` rises 1 cycle after the cycle in which the debounced step value rises.
- **Step pulse.** `CLK_OUT` is high for exactly `PULSE_LEN` cycles.
- **Edge count latency.** `EDGE_CNT` updates in the same cycle that `CLK_OUT` shows 0.
- **Run mode.**
  - Period is exactly 2×`HALF` cycles, 50% duty.
  - The first rising edge comes `HALF` cycles after entering `RUN_LO`.
- **Glitch-free outputs.** `CLK_OUT` is a direct register output; it has no combinational glitches and no pulse shorter than min(`PULSE_LEN`, `HALF`).

## Test plan
All scenarios use `DEB_CYCLES` = 4, `PULSE_LEN` = 3, `HALF` = 5.
- **Reset.** Hold `CLR` = 1 for 3 cycles with random inputs → all outputs 0 and `MODE` = 0. After release, no `CLK_OUT` activity with the buttons idle.
- **Bounce rejection.**
  - Toggle `BTN_STEP` every 2 cycles for 20 cycles, then hold it at 0 → `CLK_OUT` never rises and `EDGE_CNT` = 0.
  - Then hold `BTN_STEP` = 1 → exactly one 3-cycle pulse, and `EDGE_CNT` = 1.
- **J/K capture.** Set `SW_J` = 2'b01, `SW_K` = 2'b11 and press step; change the switches to 2'b10/2'b00 while `CLK_OUT` = 1 → `J_OUT`/`K_OUT` stay 01/11 through the falling edge. The next press loads 10/00.
- **Run mode.** Press mode → `MODE` = 1 and a square wave with 10-cycle period. After 30 periods, `EDGE_CNT` = 30, and step presses have no effect.
- **Mode exit during high phase.** Press mode while `CLK_OUT` = 1 in run mode → the high phase completes its full 5 cycles, that falling edge is counted, then `MODE` = 0 and `CLK_OUT` stays 0.
- **Wrap and mid-pulse reset.**
  - Drive 256 step pulses → `EDGE_CNT` wraps to 0.
  - Assert `CLR` during a step pulse → `CLK_OUT` = 0 and `EDGE_CNT` = 0 on the next cycle.
